// File: rtl/register_file_2r1w_if.sv
// Bus bundle for the 2-read/1-write register file: write port, two read ports,
// soft-clear request and status.
interface register_file_2r1w_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 4
) ();
  logic                 write_en;
  logic [ADDR_W-1:0]    write_addr;
  logic [WIDTH-1:0]     data_in;
  logic [WIDTH/8-1:0]   byte_en;
  logic                 read_en_a;
  logic [ADDR_W-1:0]    read_addr_a;
  logic [WIDTH-1:0]     data_out_a;
  logic                 read_en_b;
  logic [ADDR_W-1:0]    read_addr_b;
  logic [WIDTH-1:0]     data_out_b;
  logic                 clr_req;
  logic                 busy;
  logic                 wr_err;

  modport master (
    output write_en, write_addr, data_in, byte_en,
    output read_en_a, read_addr_a, read_en_b, read_addr_b, clr_req,
    input  data_out_a, data_out_b, busy, wr_err
  );

  modport slave (
    input  write_en, write_addr, data_in, byte_en,
    input  read_en_a, read_addr_a, read_en_b, read_addr_b, clr_req,
    output data_out_a, data_out_b, busy, wr_err
  );
endinterface

// File: rtl/register_file_2r1w.sv
// Register file with two registered read ports, one byte-enabled write port,
// same-cycle write-to-read bypass and a one-entry-per-cycle soft-clear sweep.
module register_file_2r1w #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter bit          ZERO_REG = 1'b0
) (
  input logic                  clk,
  input logic                  reset_n,
  register_file_2r1w_if.slave  bus
);
  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned NBYTES = WIDTH / 8;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              busy_q;
  logic              wr_err_q;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  rd_a_q, rd_a_d;
  logic [WIDTH-1:0]  rd_b_q, rd_b_d;
  logic [WIDTH-1:0]  wr_word;
  logic              wr_ok;

  // Merge enabled bytes of data_in over the old entry; decide if the write lands.
  always_comb begin
    wr_word = mem_q[bus.write_addr];
    for (int i = 0; i < NBYTES; i++) begin
      if (bus.byte_en[i]) wr_word[8*i +: 8] = bus.data_in[8*i +: 8];
    end
    // Writes to a hardwired-zero entry vanish silently (no wr_err).
    wr_ok = bus.write_en && (state_q == StIdle) && !(ZERO_REG && (bus.write_addr == '0));
  end

  // Next read data per port: zero while sweeping, bypass on address match.
  always_comb begin
    rd_a_d = rd_a_q;
    rd_b_d = rd_b_q;
    if (bus.read_en_a) begin
      if (busy_q || (ZERO_REG && (bus.read_addr_a == '0))) rd_a_d = '0;
      else if (wr_ok && (bus.read_addr_a == bus.write_addr)) rd_a_d = wr_word;
      else rd_a_d = mem_q[bus.read_addr_a];
    end
    if (bus.read_en_b) begin
      if (busy_q || (ZERO_REG && (bus.read_addr_b == '0))) rd_b_d = '0;
      else if (wr_ok && (bus.read_addr_b == bus.write_addr)) rd_b_d = wr_word;
      else rd_b_d = mem_q[bus.read_addr_b];
    end
  end

  // Soft-clear FSM with registered busy and write-error pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= bus.write_en && (state_q == StClear);
      unique case (state_q)
        StIdle: begin
          if (bus.clr_req) begin
            state_q <= StClear;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        StClear: begin
          // Counter wraps to 0 on the same edge the sweep ends.
          cnt_q <= cnt_q + ADDR_W'(1);
          if (cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Storage array: sweep clears one entry per cycle, otherwise accept writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (state_q == StClear) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_ok) begin
      mem_q[bus.write_addr] <= wr_word;
    end
  end

  // Registered read data for both ports.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_a_q <= '0;
      rd_b_q <= '0;
    end else begin
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
    end
  end

  assign bus.data_out_a = rd_a_q;
  assign bus.data_out_b = rd_b_q;
  assign bus.busy       = busy_q;
  assign bus.wr_err     = wr_err_q;
endmodule

// File: tb/tb_register_file_2r1w.sv
// Self-checking bench for register_file_2r1w: directed scenarios plus randomized
// traffic against an array-based reference model.
module tb_register_file_2r1w;
  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  register_file_2r1w_if #(.WIDTH(16), .ADDR_W(4)) bus ();
  register_file_2r1w_if #(.WIDTH(16), .ADDR_W(4)) busz ();

  register_file_2r1w #(.WIDTH(16), .ADDR_W(4), .ZERO_REG(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  register_file_2r1w #(.WIDTH(16), .ADDR_W(4), .ZERO_REG(1'b1)) dut_z (
    .clk(clk), .reset_n(reset_n), .bus(busz)
  );

  always #5 clk = ~clk;

  // Reference model: contents, read registers, error flag, remaining sweep cycles.
  logic [15:0] m_mem [16];
  logic [15:0] m_a, m_b;
  logic        m_err;
  int          m_left, m_idx;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 16'h0;
    m_a = 0; m_b = 0; m_err = 0; m_left = 0; m_idx = 0;
  endtask

  task automatic model_step();
    logic [15:0] mask, merged;
    logic busy, acc;
    busy = (m_left > 0);
    mask = {{8{bus.byte_en[1]}}, {8{bus.byte_en[0]}}};
    merged = (m_mem[bus.write_addr] & ~mask) | (bus.data_in & mask);
    acc = bus.write_en && !busy;
    if (bus.read_en_a)
      m_a = busy ? 16'h0 : (acc && bus.read_addr_a == bus.write_addr) ? merged : m_mem[bus.read_addr_a];
    if (bus.read_en_b)
      m_b = busy ? 16'h0 : (acc && bus.read_addr_b == bus.write_addr) ? merged : m_mem[bus.read_addr_b];
    m_err = bus.write_en && busy;
    if (busy) begin
      m_mem[m_idx] = 16'h0;
      m_idx++;
      m_left--;
    end else begin
      if (acc) m_mem[bus.write_addr] = merged;
      if (bus.clr_req) begin m_left = 16; m_idx = 0; end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.write_en = 0; bus.write_addr = 0; bus.data_in = 0; bus.byte_en = 0;
    bus.read_en_a = 0; bus.read_addr_a = 0; bus.read_en_b = 0; bus.read_addr_b = 0;
    bus.clr_req = 0;
  endtask

  task automatic drive_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    bus.write_en = 1; bus.write_addr = a; bus.data_in = d; bus.byte_en = be;
  endtask

  task automatic test_reset();
    set_idle();
    #1 reset_n = 1'b0;
    #2;
    checks++;
    if (bus.data_out_a !== 16'h0) begin failures++; $display("FAIL reset_a got %h want 0000", bus.data_out_a); end
    checks++;
    if (bus.data_out_b !== 16'h0) begin failures++; $display("FAIL reset_b got %h want 0000", bus.data_out_b); end
    checks++;
    if (bus.busy !== 1'b0 || bus.wr_err !== 1'b0) begin
      failures++; $display("FAIL reset_status got busy=%b wr_err=%b want 0 0", bus.busy, bus.wr_err);
    end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  // First edge after release accepts a write; read it back next cycle.
  task automatic test_first_write();
    drive_write(4'd3, 16'hA5C3, 2'b11);
    tick();
    set_idle();
    bus.read_en_a = 1; bus.read_addr_a = 4'd3;
    tick();
    set_idle();
    checks++;
    if (bus.data_out_a !== 16'hA5C3) begin
      failures++; $display("FAIL first_write got %h want a5c3", bus.data_out_a);
    end
  endtask

  task automatic test_bypass();
    drive_write(4'd5, 16'h1234, 2'b11);
    tick();
    drive_write(4'd5, 16'hFFFF, 2'b01);
    bus.read_en_b = 1; bus.read_addr_b = 4'd5;
    bus.read_en_a = 1; bus.read_addr_a = 4'd5;
    tick();
    set_idle();
    checks++;
    if (bus.data_out_b !== 16'h12FF) begin failures++; $display("FAIL bypass_b got %h want 12ff", bus.data_out_b); end
    checks++;
    if (bus.data_out_a !== 16'h12FF) begin failures++; $display("FAIL bypass_a got %h want 12ff", bus.data_out_a); end
    bus.read_en_a = 1; bus.read_addr_a = 4'd3;
    tick();
    set_idle();
    // Port B not enabled: must still hold 12ff; A now shows entry 3.
    checks++;
    if (bus.data_out_a !== 16'hA5C3 || bus.data_out_b !== 16'h12FF) begin
      failures++; $display("FAIL hold got a=%h b=%h want a5c3 12ff", bus.data_out_a, bus.data_out_b);
    end
    bus.read_en_b = 1; bus.read_addr_b = 4'd5;
    tick();
    set_idle();
    checks++;
    if (bus.data_out_b !== 16'h12FF) begin failures++; $display("FAIL entry5_after got %h want 12ff", bus.data_out_b); end
  endtask

  task automatic test_random(input int n, input bit with_clr);
    for (int c = 0; c < n; c++) begin
      bus.write_en    = 1'($urandom_range(0, 1));
      bus.write_addr  = 4'($urandom_range(0, 15));
      bus.data_in     = 16'($urandom);
      bus.byte_en     = 2'($urandom_range(0, 3));
      bus.read_en_a   = ($urandom_range(0, 9) < 7);
      bus.read_addr_a = ($urandom_range(0, 2) == 0) ? bus.write_addr : 4'($urandom_range(0, 15));
      bus.read_en_b   = ($urandom_range(0, 9) < 7);
      bus.read_addr_b = ($urandom_range(0, 2) == 0) ? bus.write_addr : 4'($urandom_range(0, 15));
      bus.clr_req     = with_clr && ($urandom_range(0, 39) == 0);
      tick();
      checks++;
      if (bus.data_out_a !== m_a) begin failures++; $display("FAIL rand_a cyc %0d got %h want %h", c, bus.data_out_a, m_a); end
      checks++;
      if (bus.data_out_b !== m_b) begin failures++; $display("FAIL rand_b cyc %0d got %h want %h", c, bus.data_out_b, m_b); end
      checks++;
      if (bus.busy !== (m_left > 0)) begin failures++; $display("FAIL rand_busy cyc %0d got %b want %b", c, bus.busy, m_left > 0); end
      checks++;
      if (bus.wr_err !== m_err) begin failures++; $display("FAIL rand_wr_err cyc %0d got %b want %b", c, bus.wr_err, m_err); end
    end
    set_idle();
    for (int c = 0; c < 20 && m_left > 0; c++) tick();
  endtask

  task automatic test_clear();
    int n_busy;
    for (int i = 0; i < 16; i++) begin
      drive_write(4'(i), 16'(16'h0101 + i * 16'h1111), 2'b11);
      tick();
    end
    // Same-cycle write and clear request: write lands, then gets swept.
    drive_write(4'd2, 16'hCAFE, 2'b11);
    bus.clr_req = 1;
    tick();
    set_idle();
    n_busy = 0;
    while (bus.busy === 1'b1 && n_busy < 40) begin
      n_busy++;
      set_idle();
      if (n_busy == 3) drive_write(4'd15, 16'hFFFF, 2'b11);
      if (n_busy == 4) begin bus.read_en_a = 1; bus.read_addr_a = 4'd15; end
      if (n_busy == 5) bus.clr_req = 1;
      tick();
      checks++;
      if (bus.wr_err !== m_err) begin failures++; $display("FAIL clr_wr_err at %0d got %b want %b", n_busy, bus.wr_err, m_err); end
      if (n_busy == 4) begin
        checks++;
        if (bus.data_out_a !== 16'h0) begin failures++; $display("FAIL clr_read_busy got %h want 0000", bus.data_out_a); end
      end
    end
    set_idle();
    checks++;
    if (n_busy != 16) begin failures++; $display("FAIL clr_busy_len got %0d want 16", n_busy); end
    for (int i = 0; i < 16; i++) begin
      bus.read_en_a = 1; bus.read_addr_a = 4'(i);
      bus.read_en_b = 1; bus.read_addr_b = 4'(15 - i);
      tick();
      checks++;
      if (bus.data_out_a !== 16'h0 || bus.data_out_b !== 16'h0 || m_a !== 16'h0) begin
        failures++; $display("FAIL clr_after entry %0d got a=%h b=%h want 0000", i, bus.data_out_a, bus.data_out_b);
      end
    end
    set_idle();
  endtask

  task automatic test_zero_reg();
    busz.write_en = 1; busz.write_addr = 4'd1; busz.data_in = 16'h1111; busz.byte_en = 2'b11;
    tick();
    busz.write_en = 0;
    busz.read_en_a = 1; busz.read_addr_a = 4'd1; busz.read_en_b = 1; busz.read_addr_b = 4'd1;
    tick();
    checks++;
    if (busz.data_out_a !== 16'h1111 || busz.data_out_b !== 16'h1111) begin
      failures++; $display("FAIL zr_entry1 got a=%h b=%h want 1111", busz.data_out_a, busz.data_out_b);
    end
    busz.write_en = 1; busz.write_addr = 4'd0; busz.data_in = 16'hBEEF; busz.byte_en = 2'b11;
    busz.read_addr_a = 4'd0; busz.read_addr_b = 4'd0;
    tick();
    busz.write_en = 0;
    checks++;
    if (busz.data_out_a !== 16'h0 || busz.data_out_b !== 16'h0) begin
      failures++; $display("FAIL zr_bypass got a=%h b=%h want 0000", busz.data_out_a, busz.data_out_b);
    end
    tick();
    checks++;
    if (busz.data_out_a !== 16'h0 || busz.data_out_b !== 16'h0) begin
      failures++; $display("FAIL zr_read0 got a=%h b=%h want 0000", busz.data_out_a, busz.data_out_b);
    end
    checks++;
    if (busz.wr_err !== 1'b0) begin failures++; $display("FAIL zr_wr_err got %b want 0", busz.wr_err); end
    busz.read_en_a = 0; busz.read_en_b = 0;
  endtask

  task automatic test_reset_mid_clear();
    for (int i = 0; i < 16; i++) begin
      drive_write(4'(i), 16'(16'h8001 + i), 2'b11);
      tick();
    end
    set_idle();
    bus.read_en_a = 1; bus.read_addr_a = 4'd4;
    bus.read_en_b = 1; bus.read_addr_b = 4'd9;
    tick();
    set_idle();
    bus.clr_req = 1;
    tick();
    set_idle();
    for (int c = 2; c <= 7; c++) begin
      if (c == 7) drive_write(4'd1, 16'h5555, 2'b11);
      tick();
      set_idle();
    end
    checks++;
    if (bus.wr_err !== 1'b1 || bus.data_out_a !== 16'h8005) begin
      failures++; $display("FAIL pre_reset got wr_err=%b a=%h want 1 8005", bus.wr_err, bus.data_out_a);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.data_out_a !== 16'h0 || bus.data_out_b !== 16'h0) begin
      failures++; $display("FAIL mid_reset_data got a=%h b=%h want 0000", bus.data_out_a, bus.data_out_b);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.wr_err !== 1'b0) begin
      failures++; $display("FAIL mid_reset_status got busy=%b wr_err=%b want 0 0", bus.busy, bus.wr_err);
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 16; i++) begin
      bus.read_en_a = 1; bus.read_addr_a = 4'(i);
      bus.read_en_b = 1; bus.read_addr_b = 4'(i);
      tick();
      checks++;
      if (bus.data_out_a !== 16'h0 || bus.data_out_b !== 16'h0 || bus.busy !== 1'b0) begin
        failures++; $display("FAIL post_reset entry %0d got a=%h b=%h busy=%b want 0", i, bus.data_out_a, bus.data_out_b, bus.busy);
      end
    end
    set_idle();
  endtask

  initial begin
    busz.write_en = 0; busz.write_addr = 0; busz.data_in = 0; busz.byte_en = 0;
    busz.read_en_a = 0; busz.read_addr_a = 0; busz.read_en_b = 0; busz.read_addr_b = 0;
    busz.clr_req = 0;
    model_reset();
    test_reset();
    test_first_write();
    test_bypass();
    test_random(300, 1'b0);
    test_clear();
    test_random(400, 1'b1);
    test_zero_reg();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/register_file_2r1w.md
REGISTER_FILE_2R1W -- requirements
Module: register_file_2r1w

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data word width in bits, multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 4: address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have parameter ZERO_REG, default 0: 1 = entry 0 hardwired to zero.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port write_en  input  1  write request this cycle.
REQ-007 SHALL have port write_addr  input  ADDR_W  write entry index.
REQ-008 SHALL have port data_in  input  WIDTH  write data.
REQ-009 SHALL have port byte_en  input  WIDTH/8  per-byte write enable; bit i covers data_in[8i+7:8i].
REQ-010 SHALL have port read_en_a  input  1  port A read request.
REQ-011 SHALL have port read_addr_a  input  ADDR_W  port A entry index.
REQ-012 SHALL have port data_out_a  output  WIDTH  port A registered read data.
REQ-013 SHALL have port read_en_b  input  1  port B read request.
REQ-014 SHALL have port read_addr_b  input  ADDR_W  port B entry index.
REQ-015 SHALL have port data_out_b  output  WIDTH  port B registered read data.
REQ-016 SHALL have port clr_req  input  1  one-cycle pulse starting soft clear of all entries.
REQ-017 SHALL have port busy  output  1  high while soft clear is in progress.
REQ-018 SHALL have port wr_err  output  1  one-cycle pulse: write dropped because busy.

Function
REQ-019 Write: with write_en=1 and busy=0, each byte i with byte_en[i]=1 SHALL be stored at write_addr at the rising edge; bytes with byte_en[i]=0 SHALL keep old value.
REQ-020 Read latency SHALL be 1 cycle: read_en_x=1 at edge N loads data_out_x with entry read_addr_x; visible after edge N.
REQ-021 With read_en_x=0, data_out_x SHALL hold its previous value.
REQ-022 Bypass: read of the address being written in the same cycle SHALL return the merged new word (enabled bytes from data_in, others from old entry), on both ports independently.
REQ-023 Ports A and B SHALL read independently, including the same address simultaneously.
REQ-024 ZERO_REG=1: reads of address 0 SHALL return 0; writes to address 0 SHALL be discarded without wr_err.
REQ-025 Soft-clear FSM SHALL have states IDLE and CLEAR; IDLE->CLEAR on clr_req=1, counter loaded with 0.
REQ-026 In CLEAR, each cycle SHALL zero entry[counter] and increment counter; on counter=DEPTH-1 that entry is zeroed and FSM returns to IDLE; CLEAR lasts exactly DEPTH cycles.
REQ-027 busy SHALL be 1 exactly while in CLEAR, i.e. from the edge after clr_req for DEPTH cycles.
REQ-028 clr_req while in CLEAR SHALL be ignored; sweep neither restarts nor extends.
REQ-029 write_en=1 while busy=1 SHALL be dropped and wr_err SHALL be 1 for the following cycle only.
REQ-030 write_en=1 and clr_req=1 in the same IDLE cycle: write SHALL complete; the entry is then zeroed by the sweep.
REQ-031 Reads while busy=1 SHALL load 0 into data_out_x.
REQ-032 Counter SHALL be ADDR_W bits; wrap from DEPTH-1 to 0 coincides with return to IDLE.

Reset
REQ-033 reset_n=0 SHALL immediately, independent of clk, zero all entries, data_out_a, data_out_b, busy, wr_err and the counter, and force IDLE.
REQ-034 Reset asserted mid-clear SHALL abort the sweep; after release FSM is IDLE with all entries 0.
REQ-035 First write SHALL be accepted on the first rising edge with reset_n=1.

Verification
REQ-036 Write 0xA5C3 to addr 3, byte_en=11; next cycle read A addr 3 -> data_out_a=0xA5C3 after one edge.
REQ-037 Entry 5=0x1234; write 0xFFFF to addr 5, byte_en=01, same-cycle read B addr 5 -> data_out_b=0x12FF; entry 5 then reads 0x12FF.
REQ-038 Fill all 16 entries nonzero; pulse clr_req -> busy high exactly 16 cycles; write during busy -> wr_err pulse, entry unchanged (0); all entries read 0 after.
REQ-039 ZERO_REG=1: write 0xBEEF to addr 0 -> reads of addr 0 on both ports return 0, wr_err stays 0.
REQ-040 Assert reset_n low mid-clear (cycle 7) between clock edges -> outputs and busy 0 immediately; after release all entries read 0, FSM IDLE.
